mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, max cycles in ACCESS before abort (>=2).
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEADBEEF, load data returned on timeout.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 memreadM  input  1  instruction in MEM stage is a load.
REQ-006 memwriteM  input  1  instruction in MEM stage is a store.
REQ-007 aluoutM  input  32  byte address of the access.
REQ-008 writedataM  input  32  store data.
REQ-009 mem_ready  input  1  memory completes the current request this cycle.
REQ-010 mem_rdata  input  32  load data, valid when mem_ready=1.
REQ-011 mem_req  output  1  request to data memory.
REQ-012 mem_we  output  1  request is a write.
REQ-013 mem_addr  output  32  request address.
REQ-014 mem_wdata  output  32  request write data.
REQ-015 readdataM  output  32  captured load data for the MEM/WB register.
REQ-016 stallM  output  1  freeze PC, IF/ID, ID/EX, EX/MEM.
REQ-017 wb_enable  output  1  MEM/WB register loads normally this cycle.
REQ-018 bubbleW  output  1  MEM/WB loads a bubble (regwrite=0, memtoreg=0); equals stallM.
REQ-019 timeout_err  output  1  sticky: an access timed out.
REQ-020 proto_err  output  1  sticky: memreadM and memwriteM both high in IDLE.
REQ-021 stall_cycles  output  16  saturating count of cycles with stallM=1.

Function
REQ-022 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-023 IDLE, no memreadM/memwriteM: stallM=0, wb_enable=1, mem_req=0, state stays IDLE.
REQ-024 IDLE, memreadM|memwriteM: stallM=1 (combinational, same cycle), wb_enable=0; latch aluoutM, writedataM, op type; next state ACCESS.
REQ-025 IDLE, both memreadM and memwriteM high: store wins, load ignored, proto_err set next edge.
REQ-026 ACCESS: mem_req=1, mem_we=latched op, mem_addr/mem_wdata=latched values, stable until completion; stallM=1, wb_enable=0.
REQ-027 ACCESS, mem_ready=1: readdataM register <= mem_rdata on loads (unchanged on stores); next state DONE.
REQ-028 ACCESS: cycle counter increments each cycle; when it reaches TIMEOUT without mem_ready, readdataM <= ERR_DATA (loads), timeout_err set, next state DONE.
REQ-029 mem_ready outside ACCESS SHALL be ignored.
REQ-030 DONE: stallM=0, wb_enable=1, mem_req=0; next state IDLE unconditionally (the completed instruction leaves MEM this edge; the following instruction is evaluated fresh in IDLE).
REQ-031 Minimum memory-op latency: op in MEM at cycle t, mem_ready at t+1, released at t+2 (2 stall cycles).
REQ-032 mem_req, mem_we, mem_addr, mem_wdata SHALL be 0 outside ACCESS.
REQ-033 stall_cycles increments every cycle stallM=1, holds at 16'hFFFF.
REQ-034 Cycle counter clears on entry to ACCESS.

Reset
REQ-035 reset=1 at an edge: state=IDLE, readdataM=0, timeout_err=0, proto_err=0, stall_cycles=0, cycle counter=0, latched address/data/op=0.
REQ-036 Reset mid-ACCESS: mem_req deasserted the cycle after the reset edge; any later mem_ready ignored.
REQ-037 While reset=1, outputs are driven from reset state (mem_req=0); stallM/wb_enable follow IDLE rules from inputs.

Verification
REQ-038 Load, addr 0x100, mem_ready at t+1, rdata 0x12345678 -> stallM=1 at t,t+1; t+2 stallM=0, wb_enable=1, readdataM=0x12345678.
REQ-039 Store, addr 0x40, data 0xA5A5A5A5, mem_ready at t+4 -> mem_req=1,mem_we=1 t+1..t+4 with stable addr/data; release t+5; readdataM unchanged; stall_cycles +=5.
REQ-040 Load with mem_ready never asserted, TIMEOUT=4 -> DONE after 4 ACCESS cycles, readdataM=0xDEADBEEF, timeout_err=1 and stays 1.
REQ-041 memreadM=memwriteM=1 -> write issued (mem_we=1), proto_err=1.
REQ-042 Reset asserted in 2nd ACCESS cycle -> next cycle mem_req=0, state IDLE, counters/flags 0; subsequent mem_ready ignored.
REQ-043 Back-to-back loads in consecutive instructions -> each takes its own IDLE->ACCESS->DONE pass; no access merged or dropped.

Source files
------------

// File: rtl/mem_stage_if.sv
// MEM-stage pipeline and data-memory signals, bundled so the controller and its
// environment share one definition.
interface mem_stage_if;
  logic        memreadM;
  logic        memwriteM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] readdataM;
  logic        stallM;
  logic        wb_enable;
  logic        bubbleW;
  logic        timeout_err;
  logic        proto_err;
  logic [15:0] stall_cycles;

  // Controller side.
  modport master (
    input  memreadM, memwriteM, aluoutM, writedataM, mem_ready, mem_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, readdataM, stallM, wb_enable,
    output bubbleW, timeout_err, proto_err, stall_cycles
  );

  // Pipeline and memory side.
  modport slave (
    output memreadM, memwriteM, aluoutM, writedataM, mem_ready, mem_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, readdataM, stallM, wb_enable,
    input  bubbleW, timeout_err, proto_err, stall_cycles
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory controller: stalls the pipeline while one load/store is
// in flight, with timeout abort and sticky error flags.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input logic         clk,
  input logic         reset,
  mem_stage_if.master bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            stateQ;
  state_e            curState;
  logic [31:0]       addrQ;
  logic [31:0]       wdataQ;
  logic              weQ;
  logic [31:0]       readdataQ;
  logic              timeoutErrQ;
  logic              protoErrQ;
  logic [15:0]       stallCntQ;
  logic [CntW-1:0]   cycCntQ;
  logic              newOp;
  logic              inAccess;
  logic              stall;

  // While reset is held the block behaves as if already in IDLE.
  always_comb begin
    curState = reset ? StIdle : stateQ;
    newOp    = (curState == StIdle) && (bus.memreadM || bus.memwriteM);
    inAccess = (curState == StAccess);
    stall    = newOp || inAccess;
  end

  always_comb begin
    bus.stallM       = stall;
    bus.bubbleW      = stall;
    bus.wb_enable    = !stall;
    bus.mem_req      = inAccess;
    bus.mem_we       = inAccess && weQ;
    bus.mem_addr     = inAccess ? addrQ : 32'h0;
    bus.mem_wdata    = inAccess ? wdataQ : 32'h0;
    bus.readdataM    = readdataQ;
    bus.timeout_err  = timeoutErrQ;
    bus.proto_err    = protoErrQ;
    bus.stall_cycles = stallCntQ;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ      <= StIdle;
      addrQ       <= 32'h0;
      wdataQ      <= 32'h0;
      weQ         <= 1'b0;
      readdataQ   <= 32'h0;
      timeoutErrQ <= 1'b0;
      protoErrQ   <= 1'b0;
      stallCntQ   <= 16'h0;
      cycCntQ     <= '0;
    end else begin
      if (stall && (stallCntQ != 16'hFFFF)) begin
        stallCntQ <= stallCntQ + 16'd1;
      end
      unique case (stateQ)
        StIdle: begin
          if (bus.memreadM || bus.memwriteM) begin
            // A store wins when both strobes are set.
            addrQ   <= bus.aluoutM;
            wdataQ  <= bus.writedataM;
            weQ     <= bus.memwriteM;
            cycCntQ <= '0;
            stateQ  <= StAccess;
            if (bus.memreadM && bus.memwriteM) begin
              protoErrQ <= 1'b1;
            end
          end
        end
        StAccess: begin
          cycCntQ <= cycCntQ + 1'b1;
          if (bus.mem_ready) begin
            if (!weQ) begin
              readdataQ <= bus.mem_rdata;
            end
            stateQ <= StDone;
          end else if (cycCntQ == CntW'(TIMEOUT - 1)) begin
            if (!weQ) begin
              readdataQ <= ERR_DATA;
            end
            timeoutErrQ <= 1'b1;
            stateQ      <= StDone;
          end
        end
        StDone:  stateQ <= StIdle;
        default: stateQ <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with TIMEOUT=4; expected values hand-derived.
module tb_mem_stage_ctrl;
  logic clk;
  logic reset;
  int   total;
  int   passed;

  mem_stage_if bus();

  mem_stage_ctrl #(
    .TIMEOUT  (4),
    .ERR_DATA (32'hDEADBEEF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #2;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    reset  = 1'b1;
    bus.memreadM   = 1'b0;
    bus.memwriteM  = 1'b0;
    bus.aluoutM    = 32'h0;
    bus.writedataM = 32'h0;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    settle();
    check("rst_readdata", bus.readdataM, 32'h0);
    check("rst_stallcnt", bus.stall_cycles, 32'h0);
    check("rst_timeout", bus.timeout_err, 32'h0);
    check("rst_proto", bus.proto_err, 32'h0);
    check("rst_memreq", bus.mem_req, 32'h0);
    check("rst_stall", bus.stallM, 32'h0);
    check("rst_wben", bus.wb_enable, 32'h1);

    // Load, ready one cycle after entry.
    tick();
    bus.memreadM = 1'b1;
    bus.aluoutM  = 32'h100;
    settle();
    check("ld_t_stall", bus.stallM, 32'h1);
    check("ld_t_wben", bus.wb_enable, 32'h0);
    check("ld_t_bubble", bus.bubbleW, 32'h1);
    check("ld_t_memreq", bus.mem_req, 32'h0);
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h12345678;
    settle();
    check("ld_t1_memreq", bus.mem_req, 32'h1);
    check("ld_t1_we", bus.mem_we, 32'h0);
    check("ld_t1_addr", bus.mem_addr, 32'h100);
    check("ld_t1_stall", bus.stallM, 32'h1);
    tick();
    bus.mem_ready = 1'b0;
    settle();
    check("ld_t2_stall", bus.stallM, 32'h0);
    check("ld_t2_wben", bus.wb_enable, 32'h1);
    check("ld_t2_memreq", bus.mem_req, 32'h0);
    check("ld_t2_rdata", bus.readdataM, 32'h12345678);
    check("ld_stallcnt", bus.stall_cycles, 32'd2);
    tick();
    bus.memreadM = 1'b0;
    settle();
    check("ld_idle_stall", bus.stallM, 32'h0);

    // Store, ready on the fourth access cycle; EX-side inputs change meanwhile.
    bus.memwriteM  = 1'b1;
    bus.aluoutM    = 32'h40;
    bus.writedataM = 32'hA5A5A5A5;
    settle();
    check("st_t_stall", bus.stallM, 32'h1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      bus.aluoutM    = 32'hFFFF0000;
      bus.writedataM = 32'h0;
      bus.mem_ready  = (i == 4);
      settle();
      check("st_memreq", bus.mem_req, 32'h1);
      check("st_we", bus.mem_we, 32'h1);
      check("st_addr", bus.mem_addr, 32'h40);
      check("st_wdata", bus.mem_wdata, 32'hA5A5A5A5);
    end
    tick();
    bus.mem_ready = 1'b0;
    settle();
    check("st_done_stall", bus.stallM, 32'h0);
    check("st_done_memreq", bus.mem_req, 32'h0);
    check("st_done_addr", bus.mem_addr, 32'h0);
    check("st_rdata_kept", bus.readdataM, 32'h12345678);
    check("st_stallcnt", bus.stall_cycles, 32'd7);
    tick();
    bus.memwriteM = 1'b0;

    // Load that never gets mem_ready: abort after four access cycles.
    bus.memreadM = 1'b1;
    bus.aluoutM  = 32'h200;
    for (int i = 1; i <= 4; i++) begin
      tick();
      settle();
      check("to_memreq", bus.mem_req, 32'h1);
    end
    tick();
    settle();
    check("to_done_stall", bus.stallM, 32'h0);
    check("to_rdata", bus.readdataM, 32'hDEADBEEF);
    check("to_err", bus.timeout_err, 32'h1);
    check("to_stallcnt", bus.stall_cycles, 32'd12);
    tick();
    bus.memreadM = 1'b0;
    tick();
    settle();
    check("to_err_sticky", bus.timeout_err, 32'h1);

    // Both strobes: store issued, protocol error flagged.
    bus.memreadM   = 1'b1;
    bus.memwriteM  = 1'b1;
    bus.aluoutM    = 32'h300;
    bus.writedataM = 32'h11112222;
    settle();
    check("pe_t_stall", bus.stallM, 32'h1);
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h55555555;
    settle();
    check("pe_we", bus.mem_we, 32'h1);
    check("pe_wdata", bus.mem_wdata, 32'h11112222);
    check("pe_flag", bus.proto_err, 32'h1);
    tick();
    bus.mem_ready = 1'b0;
    settle();
    check("pe_rdata_kept", bus.readdataM, 32'hDEADBEEF);
    check("pe_stallcnt", bus.stall_cycles, 32'd14);
    tick();
    bus.memreadM  = 1'b0;
    bus.memwriteM = 1'b0;

    // Reset during the second access cycle.
    bus.memreadM = 1'b1;
    bus.aluoutM  = 32'h400;
    tick();
    settle();
    check("rm_acc1_memreq", bus.mem_req, 32'h1);
    tick();
    reset        = 1'b1;
    bus.memreadM = 1'b0;
    settle();
    check("rm_inrst_memreq", bus.mem_req, 32'h0);
    tick();
    reset         = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h99999999;
    settle();
    check("rm_memreq", bus.mem_req, 32'h0);
    check("rm_stall", bus.stallM, 32'h0);
    check("rm_rdata", bus.readdataM, 32'h0);
    check("rm_timeout", bus.timeout_err, 32'h0);
    check("rm_proto", bus.proto_err, 32'h0);
    check("rm_stallcnt", bus.stall_cycles, 32'h0);
    tick();
    bus.mem_ready = 1'b0;
    settle();
    check("rm_ready_ignored", bus.readdataM, 32'h0);
    check("rm_idle_memreq", bus.mem_req, 32'h0);

    // Back-to-back loads.
    bus.memreadM = 1'b1;
    bus.aluoutM  = 32'h500;
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hAAAA0001;
    settle();
    check("bb1_addr", bus.mem_addr, 32'h500);
    tick();
    bus.mem_ready = 1'b0;
    settle();
    check("bb1_done_stall", bus.stallM, 32'h0);
    check("bb1_rdata", bus.readdataM, 32'hAAAA0001);
    tick();
    bus.aluoutM = 32'h504;
    settle();
    check("bb2_t_stall", bus.stallM, 32'h1);
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hBBBB0002;
    settle();
    check("bb2_addr", bus.mem_addr, 32'h504);
    check("bb2_memreq", bus.mem_req, 32'h1);
    tick();
    bus.mem_ready = 1'b0;
    bus.memreadM  = 1'b0;
    settle();
    check("bb2_rdata", bus.readdataM, 32'hBBBB0002);
    check("bb_stallcnt", bus.stall_cycles, 32'd4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
